nn_mem_reader: RTL and testbench

- Read-side sequencer for `mem_sys`; the load path writes weights and inputs into it, this block reads them back out.
- On `start`, walks every weight bank (`sel_w` = 0..NUM_W_BANKS-1) and every address 0..DEPTH-1.
- Each step issues one paired read: weight bit from `sel_w`=bank and input bit from `sel_x`=0 at the same address.
- Presents each (w, x) bit pair to the compute datapath on a valid/ready stream, then pulses `done`.

---
 rtl/nn_mem_reader.sv | 154 +++++++++++++++
 tb/tb_nn_mem_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/nn_mem_reader.sv
// Read-side sequencer for mem_sys: sweeps every weight bank and address, issuing paired
// weight/input reads and presenting each captured bit pair on a valid/ready stream.
module nn_mem_reader #(
    parameter int W_ADDR_LEN  = 20,
    parameter int W_SEL_LEN   = 2,
    parameter int X_SEL_LEN   = 2,
    parameter int NUM_W_BANKS = 4,
    parameter int DEPTH       = 8,
    parameter int IDX_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  read_rq_w,
    output logic                  read_rq_x,
    output logic [W_ADDR_LEN-1:0] rw_address,
    output logic [W_SEL_LEN-1:0]  sel_w,
    output logic [X_SEL_LEN-1:0]  sel_x,
    input  logic                  read_data_w,
    input  logic                  read_data_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_w,
    output logic                  out_x,
    output logic [IDX_W-1:0]      out_idx,
    output logic [W_SEL_LEN-1:0]  out_bank,
    output logic                  out_last
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        PRESENT,
        FIN
    } state_t;

    localparam logic [IDX_W-1:0]     IDX_MAX  = IDX_W'(DEPTH - 1);
    localparam logic [W_SEL_LEN-1:0] BANK_MAX = W_SEL_LEN'(NUM_W_BANKS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [W_SEL_LEN-1:0]   bank;
    logic                   abort_now;
    logic                   handshake;

    assign abort_now = abort && (state != IDLE);
    assign handshake = (state == PRESENT) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort_now) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = ISSUE;
                ISSUE:   state_nxt = CAPTURE;
                CAPTURE: state_nxt = PRESENT;
                PRESENT: if (handshake) state_nxt = out_last ? FIN : ISSUE;
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counters advance only on an accepted, non-final pair; the final pair leaves them at their maxima.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            bank <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                idx  <= '0;
                bank <= '0;
            end
        end else if (!abort && handshake && !out_last) begin
            if (idx == IDX_MAX) begin
                idx  <= '0;
                bank <= bank + W_SEL_LEN'(1);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Captured pair is cleared whenever the sequencer drops back to IDLE (abort or end of sweep).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_w    <= 1'b0;
            out_x    <= 1'b0;
            out_idx  <= '0;
            out_bank <= '0;
            out_last <= 1'b0;
        end else if (state_nxt == IDLE) begin
            out_w    <= 1'b0;
            out_x    <= 1'b0;
            out_idx  <= '0;
            out_bank <= '0;
            out_last <= 1'b0;
        end else if (state == CAPTURE) begin
            out_w    <= read_data_w;
            out_x    <= read_data_x;
            out_idx  <= idx;
            out_bank <= bank;
            out_last <= (bank == BANK_MAX) && (idx == IDX_MAX);
        end
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        read_rq_w  = 1'b0;
        read_rq_x  = 1'b0;
        rw_address = '0;
        sel_w      = '0;
        sel_x      = '0;
        out_valid  = 1'b0;
        case (state)
            ISSUE: begin
                busy       = 1'b1;
                read_rq_w  = 1'b1;
                read_rq_x  = 1'b1;
                rw_address = W_ADDR_LEN'(idx);
                sel_w      = bank;
            end
            CAPTURE: begin
                busy       = 1'b1;
                rw_address = W_ADDR_LEN'(idx);
                sel_w      = bank;
            end
            PRESENT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            FIN: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nn_mem_reader.sv
// Directed bench for nn_mem_reader: full sweeps with a behavioural one-cycle-latency memory,
// backpressure, abort, asynchronous reset mid-sweep and start-while-busy.
module tb_nn_mem_reader;

    localparam int W_ADDR_LEN  = 20;
    localparam int W_SEL_LEN   = 2;
    localparam int X_SEL_LEN   = 2;
    localparam int NUM_W_BANKS = 4;
    localparam int DEPTH       = 8;
    localparam int IDX_W       = 3;
    localparam int NPAIRS      = NUM_W_BANKS * DEPTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  read_rq_w;
    logic                  read_rq_x;
    logic [W_ADDR_LEN-1:0] rw_address;
    logic [W_SEL_LEN-1:0]  sel_w;
    logic [X_SEL_LEN-1:0]  sel_x;
    logic                  read_data_w = 1'b0;
    logic                  read_data_x = 1'b0;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_w;
    logic                  out_x;
    logic [IDX_W-1:0]      out_idx;
    logic [W_SEL_LEN-1:0]  out_bank;
    logic                  out_last;

    int total = 0;
    int bad   = 0;

    nn_mem_reader #(
        .W_ADDR_LEN (W_ADDR_LEN),
        .W_SEL_LEN  (W_SEL_LEN),
        .X_SEL_LEN  (X_SEL_LEN),
        .NUM_W_BANKS(NUM_W_BANKS),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .read_rq_w  (read_rq_w),
        .read_rq_x  (read_rq_x),
        .rw_address (rw_address),
        .sel_w      (sel_w),
        .sel_x      (sel_x),
        .read_data_w(read_data_w),
        .read_data_x(read_data_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_w      (out_w),
        .out_x      (out_x),
        .out_idx    (out_idx),
        .out_bank   (out_bank),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // Memory contents: weight[b][i] = (b+i)&1, x[i] = i&1; data is only valid the cycle after a request.
    always @(posedge clk) begin
        if (read_rq_w) read_data_w <= 1'((int'(sel_w) + int'(rw_address)) & 1);
        else           read_data_w <= 1'b0;
        if (read_rq_x) read_data_x <= 1'(int'(rw_address) & 1);
        else           read_data_x <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sweep(input int stall_p, input int abort_p);
        int n, p, rq_p, stall_left, last_seen, extra;
        bit fin, arm, aborted, saw_done;
        n = 0; p = 0; rq_p = 0; stall_left = 5; last_seen = -1;
        fin = 0; arm = 0; aborted = 0;
        extra = (stall_p >= 0) ? 5 : 0;
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; n = 1;
        check("lat_rq_w", read_rq_w, 1);
        check("lat_addr", rw_address, 0);
        while (!fin && !aborted && n < 200) begin
            start = (n == 20);
            if (arm) begin
                check("abort_capture_quiet", {read_rq_w, read_rq_x, out_valid}, 0);
                abort = 1'b1; arm = 0; aborted = 1;
            end
            if (read_rq_w || read_rq_x) begin
                check("rq_pair", {read_rq_w, read_rq_x}, 2'b11);
                check("rq_addr", rw_address, rq_p % DEPTH);
                check("rq_sel_w", sel_w, rq_p / DEPTH);
                check("rq_sel_x", sel_x, 0);
                if (rq_p == abort_p) arm = 1;
                rq_p++;
            end
            if (out_valid) begin
                check("present_no_rq", read_rq_w | read_rq_x, 0);
                check("pair_w", out_w, ((p / DEPTH) + (p % DEPTH)) % 2);
                check("pair_x", out_x, (p % DEPTH) % 2);
                check("pair_idx", out_idx, p % DEPTH);
                check("pair_bank", out_bank, p / DEPTH);
                check("pair_last", out_last, p == NPAIRS - 1);
                if (last_seen != p) begin
                    check("pair_cycle", n, 3 * p + 3 + ((stall_p >= 0 && p > stall_p) ? 5 : 0));
                    last_seen = p;
                end
                if (p == stall_p && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    p++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done) begin
                check("done_cycle", n, 3 * NPAIRS + 1 + extra);
                check("done_pairs", p, NPAIRS);
                check("fin_busy", busy, 0);
                fin = 1;
            end
            @(negedge clk); n++;
        end
        start = 1'b0;
        if (aborted) begin
            abort = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_outs", {out_valid, read_rq_w, read_rq_x, done, out_w, out_x, out_last}, 0);
            check("abort_regs", {out_bank, out_idx, sel_w, 12'(rw_address)}, 0);
            saw_done = 0;
            repeat (10) begin
                @(negedge clk);
                if (done) saw_done = 1;
            end
            check("abort_no_done", saw_done, 0);
        end else begin
            check("sweep_fin", fin, 1);
            check("idle_after_fin", {busy, out_valid, done}, 0);
        end
    endtask

    initial begin
        int wait_cnt;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rq", {read_rq_w, read_rq_x}, 0);
        check("rst_addr", rw_address, 0);
        check("rst_sel", {sel_w, sel_x}, 0);
        check("rst_valid", out_valid, 0);
        check("rst_pair", {out_w, out_x, out_last}, 0);
        check("rst_idx_bank", {out_idx, out_bank}, 0);
        rst = 1'b0;
        @(negedge clk);

        sweep(-1, -1);
        sweep(11, -1);
        sweep(-1, 2 * DEPTH + 5);
        sweep(-1, -1);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("rst_mid_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rq", {read_rq_w, read_rq_x}, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        sweep(-1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, bad=%0d", bad);
        $fatal(1);
    end

endmodule
